powlib_busarbiter: RTL and testbench

- Round-robin arbiter sharing one downstream bus lane between B_WRS bus writers.
- Filters each request against an address window [B_BASE, B_BASE+B_SIZE).
- Holds the grant for bursts of up to MAXBURST beats per winner.
- Decouples the downstream rdrdy from the upstream wrrdys through a 2-entry output buffer. It sits in front of a bus crossing lane or bus FIFO wherever several masters converge on one target.

---
 rtl/powlib_busarbiter.sv | 151 +++++++++++++++
 tb/tb_powlib_busarbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/powlib_busarbiter.sv
// Round-robin arbiter sharing one downstream lane between B_WRS writers, with an
// address-window filter, burst-limited grants and a 2-entry output buffer.
module powlib_busarbiter #(
    parameter int unsigned B_WRS    = 4,
    parameter int unsigned B_AW     = 2,
    parameter int unsigned B_DW     = 4,
    parameter int unsigned B_BASE   = 0,
    parameter int unsigned B_SIZE   = 2,
    parameter int unsigned MAXBURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [B_WRS*B_DW-1:0]        wrdatas,
    input  logic [B_WRS*B_AW-1:0]        wraddrs,
    input  logic [B_WRS-1:0]             wrvlds,
    output logic [B_WRS-1:0]             wrrdys,
    output logic [B_DW-1:0]              rddata,
    output logic [B_AW-1:0]              rdaddr,
    output logic                         rdvld,
    input  logic                         rdrdy,
    output logic [$clog2(B_WRS)-1:0]     gntidx,
    output logic                         busy
);

    localparam int unsigned IW = $clog2(B_WRS);
    localparam int unsigned CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam int unsigned XW = B_AW + 1;
    localparam logic [XW-1:0] WIN_LO = XW'(B_BASE);
    localparam logic [XW-1:0] WIN_SZ = XW'(B_SIZE);

    typedef struct packed {
        logic [B_AW-1:0] addr;
        logic [B_DW-1:0] data;
    } beat_t;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [IW-1:0]   gnt, gnt_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IW-1:0]   cand;
    logic            found;
    logic            push;
    logic            pop;
    logic            full;

    beat_t           wr_beat [B_WRS];
    logic [B_WRS-1:0] req;

    beat_t           mem [2];
    logic            wp;
    logic            rp;
    logic [1:0]      fcnt;

    // Window test as one unsigned compare: addresses below the base wrap to large offsets.
    for (genvar i = 0; i < B_WRS; i++) begin : g_wr
        assign wr_beat[i].addr = wraddrs[i*B_AW +: B_AW];
        assign wr_beat[i].data = wrdatas[i*B_DW +: B_DW];
        assign req[i] = wrvlds[i] &&
                        (({1'b0, wraddrs[i*B_AW +: B_AW]} - WIN_LO) < WIN_SZ);
    end

    assign full   = (fcnt == 2'd2);
    assign rdvld  = (fcnt != 2'd0);
    assign pop    = rdvld && rdrdy;
    assign rdaddr = mem[rp].addr;
    assign rddata = mem[rp].data;
    assign busy   = (state == GRANT);
    assign gntidx = gnt;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= IW'(B_WRS - 1);
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            gnt   <= gnt_nx;
            cnt   <= cnt_nx;
        end
    end

    // Arbitration, burst accounting and writer handshake.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        cnt_nx   = cnt;
        wrrdys   = '0;
        push     = 1'b0;
        cand     = ptr;
        found    = 1'b0;
        case (state)
            IDLE: begin
                for (int unsigned k = 1; k <= B_WRS; k++) begin
                    cand = IW'((32'(ptr) + k) % B_WRS);
                    if (!found && req[cand]) begin
                        found  = 1'b1;
                        gnt_nx = cand;
                    end
                end
                if (found) begin
                    cnt_nx   = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                push        = req[gnt] && !full;
                wrrdys[gnt] = push;
                if (push) begin
                    cnt_nx = cnt + CW'(1);
                end
                // A full-buffer stall keeps the grant; only burst end or a dropped request frees it.
                if ((push && (cnt == CW'(MAXBURST - 1))) || !req[gnt]) begin
                    state_nx = IDLE;
                    ptr_nx   = gnt;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Two-entry output buffer; no bypass so rdrdy never reaches wrrdys.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            fcnt   <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wr_beat[gnt];
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 2'd1;
                2'b01:   fcnt <= fcnt - 2'd1;
                default: fcnt <= fcnt;
            endcase
        end
    end

endmodule

// File: tb/tb_powlib_busarbiter.sv
// Bench for powlib_busarbiter: directed scenarios and randomized traffic, a reference
// model predicting handshakes and a scoreboard of expected output beats.
module tb_powlib_busarbiter;

    localparam int unsigned B_WRS    = 4;
    localparam int unsigned B_AW     = 2;
    localparam int unsigned B_DW     = 4;
    localparam int unsigned B_BASE   = 0;
    localparam int unsigned B_SIZE   = 2;
    localparam int unsigned MAXBURST = 4;
    localparam int unsigned IW       = $clog2(B_WRS);
    localparam int unsigned DWS      = B_WRS * B_DW;
    localparam int          NW       = int'(B_WRS);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DWS-1:0]        wrdatas;
    logic [B_WRS*B_AW-1:0] wraddrs;
    logic [B_WRS-1:0]      wrvlds;
    logic [B_WRS-1:0]      wrrdys;
    logic [B_DW-1:0]       rddata;
    logic [B_AW-1:0]       rdaddr;
    logic                  rdvld;
    logic                  rdrdy;
    logic [IW-1:0]         gntidx;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int addr;
        int data;
    } beat_t;

    beat_t exp_q[$];
    int    gnt_log[$];
    int    beats_log[$];

    always #5 clk = ~clk;

    powlib_busarbiter #(
        .B_WRS(B_WRS), .B_AW(B_AW), .B_DW(B_DW),
        .B_BASE(B_BASE), .B_SIZE(B_SIZE), .MAXBURST(MAXBURST)
    ) dut (
        .clk(clk), .rst(rst),
        .wrdatas(wrdatas), .wraddrs(wraddrs), .wrvlds(wrvlds), .wrrdys(wrrdys),
        .rddata(rddata), .rdaddr(rdaddr), .rdvld(rdvld), .rdrdy(rdrdy),
        .gntidx(gntidx), .busy(busy)
    );

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int waddr(input int i);
        return int'(wraddrs[i*B_AW +: B_AW]);
    endfunction

    function automatic int wdata(input int i);
        return int'(wrdatas[i*B_DW +: B_DW]);
    endfunction

    function automatic bit in_window(input int a);
        return (a >= int'(B_BASE)) && (a < int'(B_BASE + B_SIZE));
    endfunction

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // Reference model: owner/beat bookkeeping from the arbitration rules, buffer as a count.
    int m_owner = -1;
    int m_last  = NW - 1;
    int m_gnt   = 0;
    int m_beats = 0;
    int m_occ   = 0;

    always @(negedge clk) begin
        logic [B_WRS-1:0] req;
        logic [B_WRS-1:0] exp_rdy;
        beat_t            b;
        bit               pop;
        int               w;
        if (!rst) begin
            check("reset wrrdys", int'(wrrdys), 0);
            check("reset rdvld", int'(rdvld), 0);
            check("reset busy", int'(busy), 0);
            check("reset gntidx", int'(gntidx), 0);
            check("reset rddata", int'(rddata), 0);
            check("reset rdaddr", int'(rdaddr), 0);
            m_owner = -1;
            m_last  = NW - 1;
            m_gnt   = 0;
            m_beats = 0;
            m_occ   = 0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                req[i] = wrvlds[i] && in_window(waddr(i));
            end
            exp_rdy = '0;
            if (m_owner >= 0 && req[m_owner] && m_occ < 2) begin
                exp_rdy[m_owner] = 1'b1;
            end
            check("wrrdys", int'(wrrdys), int'(exp_rdy));
            check("wrrdys onehot", int'($countones(wrrdys) <= 1), 1);
            check("busy", int'(busy), int'(m_owner >= 0));
            check("gntidx", int'(gntidx), m_gnt);
            check("rdvld", int'(rdvld), int'(m_occ > 0));
            pop = (m_occ > 0) && rdrdy;
            if (m_owner < 0) begin
                for (int k = 1; k <= NW; k++) begin
                    w = (m_last + k) % NW;
                    if (m_owner < 0 && req[w]) begin
                        m_owner = w;
                        m_gnt   = w;
                        m_beats = 0;
                    end
                end
            end else if (exp_rdy[m_owner]) begin
                b.addr = waddr(m_owner);
                b.data = wdata(m_owner);
                exp_q.push_back(b);
                m_occ++;
                m_beats++;
                if (m_beats == int'(MAXBURST)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
            if (pop) begin
                m_occ--;
            end
        end
    end

    // Monitor: pops the scoreboard on output beats, logs grants and burst lengths, checks fairness.
    int cur_beats = 0;
    bit prev_busy = 1'b0;
    int waits[B_WRS];

    always @(negedge clk) begin
        beat_t e;
        int    g;
        if (!rst) begin
            exp_q.delete();
            gnt_log.delete();
            beats_log.delete();
            cur_beats = 0;
            prev_busy = 1'b0;
            for (int i = 0; i < NW; i++) waits[i] = 0;
        end else begin
            if (rdvld && rdrdy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra beat: got addr %0d data %0d expected no beat at %0t",
                             rdaddr, rddata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rdaddr", int'(rdaddr), e.addr);
                    check("rddata", int'(rddata), e.data);
                end
            end
            for (int i = 0; i < NW; i++) begin
                if (!(wrvlds[i] && in_window(waddr(i)))) waits[i] = 0;
            end
            if (busy && !prev_busy) begin
                g = int'(gntidx);
                gnt_log.push_back(g);
                for (int i = 0; i < NW; i++) begin
                    if (i == g) begin
                        waits[i] = 0;
                    end else if (wrvlds[i] && in_window(waddr(i))) begin
                        waits[i]++;
                        check("fairness wait", int'(waits[i] <= NW - 1), 1);
                    end
                end
            end
            if (busy && ((wrrdys & wrvlds) != '0)) cur_beats++;
            if (!busy && prev_busy) begin
                beats_log.push_back(cur_beats);
                cur_beats = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic set_addr(input int i, input int a);
        wraddrs[i*B_AW +: B_AW] = B_AW'(a);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 wrdatas = DWS'($urandom);
        end
    endtask

    initial begin
        int exp_g[5];
        int n;
        int w2;
        rst     = 1'b0;
        wrvlds  = '0;
        wraddrs = '0;
        wrdatas = '0;
        rdrdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // All writers streaming in-window: rotation 0,1,2,3,0 with full bursts.
        wrvlds = '1;
        for (int i = 0; i < NW; i++) set_addr(i, 1);
        rdrdy = 1'b1;
        step(30);
        exp_g = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            check("p1 grant order", at(gnt_log, k), exp_g[k]);
            check("p1 burst length", at(beats_log, k), int'(MAXBURST));
        end

        // Out-of-window writer 2 is never served; writer 1 gets every grant.
        do_reset();
        wrvlds = 4'b0110;
        set_addr(1, 0);
        set_addr(2, 3);
        w2 = 0;
        repeat (50) begin
            @(negedge clk);
            if (wrrdys[2]) w2++;
            @(posedge clk);
            #1 wrdatas = DWS'($urandom);
        end
        check("p2 wrrdys2 high cycles", w2, 0);
        check("p2 any grant", int'(gnt_log.size() > 0), 1);
        for (int k = 0; k < gnt_log.size(); k++) check("p2 grant idx", gnt_log[k], 1);

        // Writer 0 drops after 2 beats; waiting writer 3 takes the next grant.
        do_reset();
        wrvlds = 4'b1001;
        set_addr(0, 1);
        set_addr(3, 1);
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (wrrdys[0]) n++;
        end
        check("p3 beats before drop", n, 2);
        @(posedge clk);
        #1 wrvlds[0] = 1'b0;
        step(10);
        check("p3 first grant", at(gnt_log, 0), 0);
        check("p3 second grant", at(gnt_log, 1), 3);
        check("p3 first burst length", at(beats_log, 0), 2);

        // Back-pressure: two beats fill the buffer, grant held, burst completes after drain.
        do_reset();
        wrvlds = 4'b0010;
        set_addr(1, 0);
        rdrdy = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (wrrdys[1]) n++;
            @(posedge clk);
            #1 wrdatas = DWS'($urandom);
        end
        check("p4 accepted while stalled", n, 2);
        check("p4 busy held", int'(busy), 1);
        check("p4 rdvld", int'(rdvld), 1);
        check("p4 wrrdys when full", int'(wrrdys), 0);
        rdrdy = 1'b1;
        step(12);
        check("p4 burst length", at(beats_log, 0), int'(MAXBURST));

        // Asynchronous reset with a full buffer, then writer 0 wins first.
        do_reset();
        wrvlds = 4'b0010;
        set_addr(1, 0);
        rdrdy = 1'b0;
        step(6);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("p5 async rdvld", int'(rdvld), 0);
        check("p5 async wrrdys", int'(wrrdys), 0);
        check("p5 async busy", int'(busy), 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        wrvlds = '1;
        for (int i = 0; i < NW; i++) set_addr(i, 0);
        rdrdy = 1'b1;
        step(10);
        check("p5 first grant after reset", at(gnt_log, 0), 0);

        // Randomized traffic with sticky valids and addresses.
        repeat (10000) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NW; i++) begin
                if ($urandom_range(9) == 0) wrvlds[i] = ~wrvlds[i];
                if ($urandom_range(7) == 0) set_addr(i, int'($urandom_range(3)));
            end
            wrdatas = DWS'($urandom);
            rdrdy   = ($urandom_range(3) != 0);
        end
        wrvlds = '0;
        rdrdy  = 1'b1;
        step(10);
        check("drain leftover beats", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
